// File: rtl/sc_bottomsidecomparator_multi.sv
// Multi-channel bottom-side comparator: matches CHANNELS rows against a pattern,
// debounces over consecutive hit samples and latches a sticky flag with the channel index.
module sc_bottomsidecomparator_multi #(
  parameter int unsigned BOTTOMSIDECOMPARATOR_DATAWIDTH  = 8,
  parameter int unsigned BOTTOMSIDECOMPARATOR_CHANNELS   = 4,
  parameter int unsigned BOTTOMSIDECOMPARATOR_COUNTWIDTH = 4
) (
  input  logic SC_BOTTOMSIDECOMPARATOR_CLOCK_50,
  input  logic SC_BOTTOMSIDECOMPARATOR_RESET_InHigh,
  input  logic SC_BOTTOMSIDECOMPARATOR_clear_InHigh,
  input  logic SC_BOTTOMSIDECOMPARATOR_sample_InHigh,
  input  logic SC_BOTTOMSIDECOMPARATOR_mode_In,
  input  logic [BOTTOMSIDECOMPARATOR_DATAWIDTH-1:0] SC_BOTTOMSIDECOMPARATOR_pattern_InBUS,
  input  logic [BOTTOMSIDECOMPARATOR_CHANNELS*BOTTOMSIDECOMPARATOR_DATAWIDTH-1:0] SC_BOTTOMSIDECOMPARATOR_data_InBUS,
  input  logic [BOTTOMSIDECOMPARATOR_COUNTWIDTH-1:0] SC_BOTTOMSIDECOMPARATOR_threshold_InBUS,
  output logic SC_BOTTOMSIDECOMPARATOR_bottomside_OutHigh,
  output logic SC_BOTTOMSIDECOMPARATOR_pulse_OutHigh,
  output logic [((BOTTOMSIDECOMPARATOR_CHANNELS > 1) ? $clog2(BOTTOMSIDECOMPARATOR_CHANNELS) : 1)-1:0] SC_BOTTOMSIDECOMPARATOR_channel_OutBUS,
  output logic [BOTTOMSIDECOMPARATOR_COUNTWIDTH-1:0] SC_BOTTOMSIDECOMPARATOR_hitcount_OutBUS
);

  localparam int unsigned DW   = BOTTOMSIDECOMPARATOR_DATAWIDTH;
  localparam int unsigned CH   = BOTTOMSIDECOMPARATOR_CHANNELS;
  localparam int unsigned CW   = BOTTOMSIDECOMPARATOR_COUNTWIDTH;
  localparam int unsigned IDXW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {IDLE, COUNTING, LOCKED} stateE;

  stateE           stateQ;
  logic [CW-1:0]   countQ;
  logic            flagQ;
  logic            pulseQ;
  logic [IDXW-1:0] channelQ;

  logic            anyHit;
  logic [IDXW-1:0] hitIdx;
  logic [DW-1:0]   row;
  logic [CW-1:0]   thrEff;
  logic [CW-1:0]   countInc;

  // Per-channel match; scanning downward leaves the lowest matching index in hitIdx
  always_comb begin
    anyHit = 1'b0;
    hitIdx = '0;
    row    = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      row = SC_BOTTOMSIDECOMPARATOR_data_InBUS[k*DW +: DW];
      if (SC_BOTTOMSIDECOMPARATOR_mode_In ? (|(row & SC_BOTTOMSIDECOMPARATOR_pattern_InBUS))
                                          : (row == SC_BOTTOMSIDECOMPARATOR_pattern_InBUS)) begin
        anyHit = 1'b1;
        hitIdx = IDXW'(k);
      end
    end
  end

  assign thrEff   = (SC_BOTTOMSIDECOMPARATOR_threshold_InBUS == '0) ? CW'(1)
                                                                    : SC_BOTTOMSIDECOMPARATOR_threshold_InBUS;
  assign countInc = (countQ == {CW{1'b1}}) ? countQ : countQ + CW'(1);

  // Debounce FSM; clear wins over a simultaneous sample
  always_ff @(posedge SC_BOTTOMSIDECOMPARATOR_CLOCK_50 or posedge SC_BOTTOMSIDECOMPARATOR_RESET_InHigh) begin
    if (SC_BOTTOMSIDECOMPARATOR_RESET_InHigh) begin
      stateQ   <= IDLE;
      countQ   <= '0;
      flagQ    <= 1'b0;
      pulseQ   <= 1'b0;
      channelQ <= '0;
    end else begin
      pulseQ <= 1'b0;
      if (SC_BOTTOMSIDECOMPARATOR_clear_InHigh) begin
        stateQ   <= IDLE;
        countQ   <= '0;
        flagQ    <= 1'b0;
        channelQ <= '0;
      end else begin
        case (stateQ)
          IDLE: begin
            if (SC_BOTTOMSIDECOMPARATOR_sample_InHigh && anyHit) begin
              countQ <= CW'(1);
              if (thrEff == CW'(1)) begin
                stateQ   <= LOCKED;
                flagQ    <= 1'b1;
                pulseQ   <= 1'b1;
                channelQ <= hitIdx;
              end else begin
                stateQ <= COUNTING;
              end
            end
          end
          COUNTING: begin
            if (SC_BOTTOMSIDECOMPARATOR_sample_InHigh) begin
              if (anyHit) begin
                countQ <= countInc;
                if (countInc >= thrEff) begin
                  stateQ   <= LOCKED;
                  flagQ    <= 1'b1;
                  pulseQ   <= 1'b1;
                  channelQ <= hitIdx;
                end
              end else begin
                countQ <= '0;
                stateQ <= IDLE;
              end
            end
          end
          LOCKED: ;
          default: stateQ <= IDLE;
        endcase
      end
    end
  end

  assign SC_BOTTOMSIDECOMPARATOR_bottomside_OutHigh = flagQ;
  assign SC_BOTTOMSIDECOMPARATOR_pulse_OutHigh      = pulseQ;
  assign SC_BOTTOMSIDECOMPARATOR_channel_OutBUS     = channelQ;
  assign SC_BOTTOMSIDECOMPARATOR_hitcount_OutBUS    = countQ;

endmodule
